// File: rtl/spi_host_pkg.sv
`default_nettype none
// ============================================================================
// spi_host_pkg : shared types and defaults for the SPI host engine. rev 1.0
// ============================================================================
package spi_host_pkg;

  localparam int   DEF_DATA_W       = 8;
  localparam int   DEF_CLKDIV_W     = 8;
  localparam logic IRQ_ACTIVE_STATE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// spi_clk_div : half-period tick generator, tick on last cycle of each
// half-period of (div+1) clocks. rev 1.0
// ============================================================================
module spi_clk_div
  import spi_host_pkg::*;
#(
  parameter int CLKDIV_W = DEF_CLKDIV_W
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                enable,
  input  logic [CLKDIV_W-1:0] div,
  output logic                tick
);

  logic [CLKDIV_W-1:0] cnt_q;
  logic [CLKDIV_W-1:0] cnt_d;

  // Wrapping at div means the counter never exceeds div, so max div is safe.
  always_comb begin
    tick  = enable && (cnt_q == div);
    cnt_d = cnt_q + 1'b1;
    if (!enable || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_xfer_engine.sv
`default_nettype none
// ============================================================================
// spi_xfer_engine : single-frame SPI master (CPOL/CPHA, MSB first). rev 1.0
// ============================================================================
module spi_xfer_engine
  import spi_host_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CLKDIV_W = DEF_CLKDIV_W
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [DATA_W-1:0]   tx_data,
  input  logic                cpol,
  input  logic                cpha,
  input  logic [CLKDIV_W-1:0] clk_div,
  input  logic                miso,
  output logic                sclk,
  output logic                mosi,
  output logic                cs_n,
  output logic [DATA_W-1:0]   rx_data,
  output logic                rx_valid,
  output logic                busy
);

  localparam int               c_hp_w    = $clog2(2 * DATA_W);
  localparam logic [c_hp_w-1:0] c_hp_last = c_hp_w'(2 * DATA_W - 1);

  spi_state_e          state_q, state_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic [CLKDIV_W-1:0] div_q, div_d;
  logic [c_hp_w-1:0]   hp_q, hp_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                cs_n_q, cs_n_d;

  logic                w_tick;
  logic                w_in_shift;
  logic                w_leading;
  logic                w_sample;
  logic                w_shift_tx;

  spi_clk_div #(
    .CLKDIV_W (CLKDIV_W)
  ) u_clk_div (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .enable  (state_q != IDLE),
    .div     (div_q),
    .tick    (w_tick)
  );

  // Even half-periods end on a leading edge, odd ones on a trailing edge.
  always_comb begin
    w_in_shift = (state_q == SHIFT) && w_tick;
    w_leading  = ~hp_q[0];
    w_sample   = w_in_shift && (hp_q[0] == cpha_q);
    w_shift_tx = w_in_shift && (cpha_q ? (w_leading && (hp_q != '0))
                                       : (!w_leading && (hp_q != c_hp_last)));

    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    div_d      = div_q;
    hp_d       = hp_q;
    sclk_d     = sclk_q;

    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (start_valid) begin
          state_d = SETUP;
          tx_sh_d = tx_data;
          cpol_d  = cpol;
          cpha_d  = cpha;
          div_d   = clk_div;
          hp_d    = '0;
        end
      end
      SETUP: begin
        sclk_d = cpol_q;
        if (w_tick) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (w_tick) begin
          sclk_d = ~sclk_q;
          if (hp_q == c_hp_last) begin
            state_d = HOLD;
            hp_d    = '0;
          end else begin
            hp_d = hp_q + 1'b1;
          end
        end
      end
      default: begin
        sclk_d = cpol_q;
        if (w_tick) begin
          state_d    = IDLE;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
        end
      end
    endcase

    if (w_sample) begin
      rx_sh_d = (rx_sh_q << 1) | DATA_W'(miso);
    end
    if (w_shift_tx) begin
      tx_sh_d = tx_sh_q << 1;
    end

    // Pins are registered off next-state so cs_n never glitches on encoding.
    cs_n_d = (state_d == IDLE);
    mosi_d = (state_d != IDLE) ? tx_sh_d[DATA_W-1] : 1'b0;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      div_q      <= '0;
      hp_q       <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      div_q      <= div_d;
      hp_q       <= hp_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign sclk        = sclk_q;
  assign mosi        = mosi_q;
  assign cs_n        = cs_n_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_engine.sv
`default_nettype none
// ============================================================================
// tb_spi_xfer_engine : directed + random frames against a per-cycle waveform
// model of the SPI frame. rev 1.0
// ============================================================================
module tb_spi_xfer_engine;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          start_valid;
  logic          start_ready;
  logic [DW-1:0] tx_data;
  logic          cpol;
  logic          cpha;
  logic [CW-1:0] clk_div;
  logic          miso;
  logic          sclk;
  logic          mosi;
  logic          cs_n;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_end_cyc = 0;

  spi_xfer_engine #(
    .DATA_W   (DW),
    .CLKDIV_W (CW)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .tx_data     (tx_data),
    .cpol        (cpol),
    .cpha        (cpha),
    .clk_div     (clk_div),
    .miso        (miso),
    .sclk        (sclk),
    .mosi        (mosi),
    .cs_n        (cs_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge ACLK);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected {cs_n, sclk, mosi, busy, start_ready, rx_valid} n cycles after
  // the accept edge. Frame = H setup, 2*DW half-periods, H hold.
  function automatic logic [5:0] model(int n, int h, logic [DW-1:0] tx, logic cp, logic ph);
    int t;
    int k;
    int i;
    t = 2 * DW * h;
    if (n == t + 2 * h) return {1'b1, cp, 1'b0, 1'b0, 1'b1, 1'b1};
    if (n < h)          k = -1;
    else if (n < h + t) k = (n - h) / h;
    else                k = 2 * DW;
    if (k < 0)            i = 0;
    else if (k >= 2 * DW) i = DW - 1;
    else if (!ph)         i = k / 2;
    else                  i = (k == 0) ? 0 : (k - 1) / 2;
    return {1'b0, (k >= 0 && k < 2 * DW) ? (cp ^ k[0]) : cp, tx[DW-1-i], 1'b1, 1'b0, 1'b0};
  endfunction

  // Slave data: the correct bit only in the half-period that ends on the
  // sampling edge, its complement in the other one.
  function automatic logic slave_bit(int n, int h, logic ph, logic [DW-1:0] pat);
    int k;
    logic b;
    if (n < h || n >= h + 2 * DW * h) return 1'($urandom);
    k = (n - h) / h;
    b = pat[DW-1-k/2];
    return (k[0] == ph) ? b : ~b;
  endfunction

  // mode: 0 loopback, 1 slave pattern, 2 tied high
  task automatic run_frame(input logic [DW-1:0] tx, input logic cp, input logic ph,
                           input logic [CW-1:0] dv, input int mode, input logic [DW-1:0] pat,
                           input bit scramble, input bit hold_valid, input bit check_gap,
                           input int abort_n);
    int            h;
    int            last;
    int            rises;
    logic          prev_sclk;
    logic          idle_cp;
    logic [DW-1:0] exp_rx;
    int            pulses;
    h      = int'(dv) + 1;
    last   = (2 * DW + 2) * h;
    rises  = 0;
    exp_rx = (mode == 0) ? tx : (mode == 1) ? pat : {DW{1'b1}};

    for (int w = 0; w < 20 && start_ready !== 1'b1; w++) step();
    check("ready_before_accept", 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    tx_data     = tx;
    cpol        = cp;
    cpha        = ph;
    clk_div     = dv;
    step();
    if (check_gap) check("accept_gap", 32'(cyc - last_end_cyc), 32'd1);
    prev_sclk = sclk;

    for (int n = 0; n <= last; n++) begin
      check($sformatf("wave@%0d", n),
            32'({cs_n, sclk, mosi, busy, start_ready, rx_valid}),
            32'(model(n, h, tx, cp, ph)));
      if (n > 0 && !prev_sclk && sclk) rises++;
      prev_sclk = sclk;
      if (n == abort_n) begin
        ARESETN = 1'b0;
        start_valid = 1'b0;
        step();
        check("abort_outputs", 32'({cs_n, sclk, busy, rx_valid, mosi}), 32'b10000);
        ARESETN = 1'b1;
        step();
        check("abort_ready", 32'({start_ready, cs_n}), 32'b11);
        pulses = 0;
        for (int j = 0; j < 4; j++) begin
          if (rx_valid) pulses++;
          step();
        end
        check("abort_no_rx_valid", 32'(pulses), 32'd0);
        return;
      end
      start_valid = hold_valid;
      if (scramble) begin
        tx_data = DW'($urandom);
        cpol    = 1'($urandom);
        cpha    = 1'($urandom);
        clk_div = CW'($urandom);
      end
      if (mode == 0)      miso = mosi;
      else if (mode == 1) miso = slave_bit(n, h, ph, pat);
      else                miso = 1'b1;
      if (n < last) step();
    end

    check("rx_data", 32'(rx_data), 32'(exp_rx));
    check("sclk_rises", 32'(rises), 32'(DW));
    last_end_cyc = cyc;
    if (!hold_valid) begin
      idle_cp = scramble ? 1'($urandom) : cp;
      cpol = idle_cp;
      step();
      check("post_frame", 32'({cs_n, sclk, mosi, busy, start_ready, rx_valid}),
            32'({1'b1, idle_cp, 1'b0, 1'b0, 1'b1, 1'b0}));
      check("rx_data_held", 32'(rx_data), 32'(exp_rx));
    end
  endtask

  initial begin
    ARESETN     = 1'b0;
    start_valid = 1'b0;
    tx_data     = '0;
    cpol        = 1'b0;
    cpha        = 1'b0;
    clk_div     = '0;
    miso        = 1'b0;
    repeat (3) step();
    check("reset_outputs", 32'({cs_n, sclk, mosi, busy, rx_valid}), 32'b10000);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    ARESETN = 1'b1;
    step();
    check("ready_after_release", 32'({start_ready, busy}), 32'b10);

    // Mode 0 loopback, H=2: 36-cycle frame.
    run_frame(8'hA5, 1'b0, 1'b0, 8'd1, 0, 8'h00, 1'b0, 1'b0, 1'b0, -1);
    // Mode 3 against slave 0xC3, H=4: 72-cycle frame, idles high.
    run_frame(8'h3C, 1'b1, 1'b1, 8'd3, 1, 8'hC3, 1'b0, 1'b0, 1'b0, -1);
    // Fastest clock, miso tied high.
    run_frame(8'h00, 1'b0, 1'b0, 8'd0, 2, 8'h00, 1'b0, 1'b0, 1'b0, -1);
    // Back-to-back with start_valid held.
    run_frame(8'h5A, 1'b0, 1'b1, 8'd1, 1, 8'h96, 1'b0, 1'b1, 1'b0, -1);
    run_frame(8'hC6, 1'b1, 1'b0, 8'd0, 0, 8'h00, 1'b0, 1'b0, 1'b1, -1);
    // Reset at SHIFT bit 4 (half-period 8), then a clean frame.
    run_frame(8'hF0, 1'b0, 1'b0, 8'd2, 1, 8'h5B, 1'b0, 1'b0, 1'b0, 9 * 3);
    run_frame(8'h81, 1'b0, 1'b0, 8'd1, 0, 8'h00, 1'b0, 1'b0, 1'b0, -1);
    // Inputs change every cycle mid-frame.
    run_frame(8'h96, 1'b1, 1'b0, 8'd2, 1, 8'h69, 1'b1, 1'b0, 1'b0, -1);
    // Maximum divider.
    run_frame(8'hB7, 1'b0, 1'b1, 8'hFF, 1, 8'h2D, 1'b0, 1'b0, 1'b0, -1);

    for (int i = 0; i < 10; i++) begin
      run_frame(DW'($urandom), 1'($urandom), 1'($urandom), CW'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), DW'($urandom), 1'($urandom), 1'b0, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_xfer_engine.md
SPI_XFER_ENGINE -- requirements
Module: spi_xfer_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per SPI frame.
REQ-002 SHALL have parameter CLKDIV_W, default 8, meaning width of the clock-divider field.
REQ-003 SHALL have port ACLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port ARESETN, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start_valid, input, 1 bit: the register block requests a frame.
REQ-006 SHALL have port start_ready, output, 1 bit: the engine can accept a frame.
REQ-007 SHALL have port tx_data, input, DATA_W bits: frame to transmit, MSB first.
REQ-008 SHALL have port cpol, input, 1 bit: SCLK idle level.
REQ-009 SHALL have port cpha, input, 1 bit: 0 means sample on the leading edge; 1 means sample on the trailing edge.
REQ-010 SHALL have port clk_div, input, CLKDIV_W bits: half-period H equals clk_div+1 ACLK cycles.
REQ-011 SHALL have port miso, input, 1 bit: serial data in, already synchronised.
REQ-012 SHALL have port sclk, output, 1 bit: SPI clock.
REQ-013 SHALL have port mosi, output, 1 bit: serial data out.
REQ-014 SHALL have port cs_n, output, 1 bit: active-low chip select.
REQ-015 SHALL have port rx_data, output, DATA_W bits: last received frame.
REQ-016 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data is updated; it feeds the interrupt pending bit.
REQ-017 SHALL have port busy, output, 1 bit: high in every non-IDLE state.

Function
REQ-018 Handshake: a frame SHALL be accepted when start_valid && start_ready on a rising edge; start_ready SHALL equal (state==IDLE).
REQ-019 On accept, tx_data, cpol, cpha and clk_div SHALL be latched; later input changes SHALL have no effect until the next accept.
REQ-020 FSM states SHALL be IDLE, SETUP, SHIFT and HOLD.
- IDLE -> SETUP on accept.
- SETUP -> SHIFT after H cycles.
- SHIFT -> HOLD after 2*DATA_W half-periods.
- HOLD -> IDLE after H cycles.
REQ-021 cs_n SHALL go low the cycle after accept and return high on entry to IDLE.
REQ-022 Total frame time from the accept edge to cs_n high SHALL be (2*DATA_W+2)*H cycles; for DATA_W=8 this is 18H.
REQ-023 sclk SHALL equal the latched cpol in SETUP and HOLD, and SHALL toggle at the end of every half-period in SHIFT (2*DATA_W toggles).
REQ-024 In IDLE, sclk SHALL follow the live cpol input, registered.
REQ-025 CPHA=0: mosi SHALL present the MSB from SETUP entry; miso SHALL be sampled on each leading edge; mosi SHALL shift on each trailing edge except the last.
REQ-026 CPHA=1: mosi SHALL shift on each leading edge (the first leading edge presents the MSB); miso SHALL be sampled on each trailing edge.
REQ-027 The receive shift register SHALL shift left, inserting miso at the LSB.
REQ-028 rx_data SHALL load and rx_valid SHALL pulse for exactly one cycle on the HOLD->IDLE transition.
REQ-029 In IDLE, mosi SHALL be 0 and rx_data SHALL hold its previous value.
REQ-030 start_valid while busy SHALL be ignored and not queued; the requester holds start_valid until ready.
REQ-031 clk_div=0 (H=1) SHALL be legal, giving SCLK = ACLK/2.
REQ-032 clk_div at its maximum SHALL count without overflow.
REQ-033 An accept in the same cycle as the HOLD->IDLE transition SHALL NOT occur, because start_ready is low in HOLD; the minimum gap between frames is one IDLE cycle with cs_n high.

Reset
REQ-034 ARESETN low at a rising edge SHALL force the following outputs:
- state IDLE
- cs_n=1
- sclk=0
- mosi=0
- rx_data=0
- rx_valid=0
- busy=0
- start_ready=1 from the first cycle after release
- divider counter 0
- shift registers 0
REQ-035 Reset during a frame SHALL abort it with no rx_valid; cs_n SHALL be high by the edge after reset is sampled.

Structure
REQ-036 Package spi_host_pkg SHALL hold the state enum typedef, the DATA_W and CLKDIV_W defaults, and the constant IRQ_ACTIVE_STATE=1.
REQ-037 The half-period tick generator SHALL be a sub-module spi_clk_div.
- Inputs: ACLK, ARESETN, enable, div.
- Output: tick, high on the last cycle of each half-period.
- The counter SHALL clear when not enabled.
REQ-038 The engine SHALL contain no AXI logic; the AXI-lite register slave instantiates it and maps rx_valid into the interrupt pending register.

Verification
REQ-039 Mode 0, clk_div=1, tx 0xA5, mosi looped to miso: rx_data=0xA5; rx_valid one pulse at the accept edge +36 cycles; 8 rising edges of sclk.
REQ-040 Mode 3, clk_div=3, tx 0x3C, miso driven from a slave model returning 0xC3: rx_data=0xC3; sclk idles high; frame time 72 cycles.
REQ-041 clk_div=0, miso tied 1, tx 0x00: rx_data=0xFF; sclk period 2 cycles; mosi constant 0.
REQ-042 start_valid held high continuously over two frames: second accept exactly one cycle after cs_n rises; start_ready low throughout the first frame.
REQ-043 ARESETN pulsed low at SHIFT bit 4: cs_n=1, sclk=0, busy=0, no rx_valid; the next frame 0x81 completes correctly.
REQ-044 Change tx_data, cpol and clk_div mid-frame: the waveform is unchanged from the latched values (bit-exact against the reference model).
